// File: rtl/sparrow_lsu.sv
// sparrow_lsu: memory-stage load/store unit (request/grant/response data bus)
//   Size encoding on i_byte_en: 00 BYTE, 01 HALF_WORD, 1x WORD.
//   Optional feature macro: SPARROW_LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
//   Ports: i_clk, i_rst_n (async active-low); decoder fields i_req/i_wr_en/i_byte_en/i_zero_extend;
//          i_addr, i_wr_data; pipeline o_stall; load result o_rd_valid/o_rd_data;
//          o_misaligned, o_bus_err pulses; bus o_mem_req/we/addr/be/wdata, i_mem_gnt/rvalid/rdata.
module sparrow_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wr_en,
    input  logic [1:0]  i_byte_en,
    input  logic        i_zero_extend,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    output logic        o_stall,
    output logic        o_rd_valid,
    output logic [31:0] o_rd_data,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d, zext_q, zext_d, err_q, err_d;
    logic [1:0]    size_q, size_d, off_q, off_d, off_n;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d, fmt;
    logic [3:0]    be_q, be_d;
    logic [15:0]   shifted;
    logic          misalign, accept, tmo;
`ifdef SPARROW_LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign misalign = (i_byte_en == HALF_WORD) ? i_addr[0] : (i_byte_en != BYTE) && (i_addr[1:0] != 2'b00);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) mis_q <= 1'b0;
        else          mis_q <= (state_q == S_IDLE) && i_req && misalign;
    end
    assign o_misaligned = mis_q;
`else
    assign misalign = 1'b0;
    assign o_misaligned = 1'b0;
`endif
    assign accept = i_req && !misalign;
    // Offset is truncated to natural alignment, so untrapped misaligned accesses stay in-word.
    assign off_n = (i_byte_en == BYTE) ? i_addr[1:0] : (i_byte_en == HALF_WORD) ? {i_addr[1], 1'b0} : 2'b00;
    assign shifted = 16'(i_mem_rdata >> {off_q, 3'b000});
    assign fmt = (size_q == BYTE) ? {{24{~zext_q & shifted[7]}}, shifted[7:0]} :
                 (size_q == HALF_WORD) ? {{16{~zext_q & shifted[15]}}, shifted[15:0]} : i_mem_rdata;
    assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        zext_d     = zext_q;
        size_d     = size_q;
        off_d      = off_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        err_d      = 1'b0;
        o_stall    = 1'b0;
        o_mem_req  = 1'b0;
        o_rd_valid = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_REQ;
                cnt_d   = '0;
                we_d    = i_wr_en;
                zext_d  = i_zero_extend;
                size_d  = i_byte_en;
                off_d   = off_n;
                addr_d  = {i_addr[31:2], 2'b00};
                be_d    = (i_byte_en == BYTE) ? 4'b0001 << off_n : (i_byte_en == HALF_WORD) ? 4'b0011 << off_n : 4'b1111;
                wdata_d = (i_byte_en == BYTE) ? {4{i_wr_data[7:0]}} : (i_byte_en == HALF_WORD) ? {2{i_wr_data[15:0]}} : i_wr_data;
                o_stall = 1'b1;
            end
            S_REQ: if (tmo) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                o_stall   = 1'b1;
                o_mem_req = 1'b1;
                cnt_d     = i_mem_gnt ? '0 : cnt_q + CW'(1);
                state_d   = i_mem_gnt ? S_WAIT : S_REQ;
            end
            S_WAIT: if (i_mem_rvalid) begin
                state_d    = S_IDLE;
                o_rd_valid = !we_q;
                rd_d       = we_q ? rd_q : fmt;
            end else if (tmo) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                o_stall = 1'b1;
                cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            zext_q  <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            zext_q  <= zext_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end
    // Load data is live in the completion cycle; afterwards the registered copy is shown.
    assign o_rd_data   = o_rd_valid ? fmt : rd_q;
    assign o_bus_err   = err_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;
endmodule

// File: tb/tb_sparrow_lsu.sv
// tb_sparrow_lsu: directed scoreboard bench for sparrow_lsu (default and 4-cycle timeout instances)
module tb_sparrow_lsu;
    localparam logic [1:0] BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req = 0, wr_en = 0, zext = 0, gnt = 0, rvalid = 0;
    logic [1:0] sz = 2'b00;
    logic [31:0] addr = 0, wdata = 0, rdata = 0;
    logic stall, rd_valid, mis, berr, mreq, mwe;
    logic [31:0] rd_data, maddr, mwdata;
    logic [3:0] mbe;
    logic t_stall, t_rd_valid, t_mis, t_berr, t_mreq, t_mwe;
    logic [31:0] t_rd_data, t_maddr, t_mwdata;
    logic [3:0] t_mbe;
    logic [105:0] all_out, t_all_out;
    exp_t sb[$];
    logic [31:0] last_rd = 0;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    sparrow_lsu dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr_en(wr_en), .i_byte_en(sz), .i_zero_extend(zext),
        .i_addr(addr), .i_wr_data(wdata), .o_stall(stall), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
        .o_misaligned(mis), .o_bus_err(berr), .o_mem_req(mreq), .o_mem_we(mwe), .o_mem_addr(maddr),
        .o_mem_be(mbe), .o_mem_wdata(mwdata), .i_mem_gnt(gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata)
    );
    sparrow_lsu #(.TIMEOUT_CYCLES(4)) dut_t (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr_en(wr_en), .i_byte_en(sz), .i_zero_extend(zext),
        .i_addr(addr), .i_wr_data(wdata), .o_stall(t_stall), .o_rd_valid(t_rd_valid), .o_rd_data(t_rd_data),
        .o_misaligned(t_mis), .o_bus_err(t_berr), .o_mem_req(t_mreq), .o_mem_we(t_mwe), .o_mem_addr(t_maddr),
        .o_mem_be(t_mbe), .o_mem_wdata(t_mwdata), .i_mem_gnt(gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata)
    );
    assign all_out = {stall, rd_valid, rd_data, mis, berr, mreq, mwe, maddr, mbe, mwdata};
    assign t_all_out = {t_stall, t_rd_valid, t_rd_data, t_mis, t_berr, t_mreq, t_mwe, t_maddr, t_mbe, t_mwdata};
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Entered just after a rising edge; returns just after the edge following completion.
    task automatic run_op(input string tag, input logic we, input logic [1:0] s, input logic zx,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bus,
                          input int gdly, input int rdly, input logic chk_t, input exp_t e);
        exp_t g;
        req = 1; wr_en = we; sz = s; zext = zx; addr = a; wdata = wd;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_acc_stall"}, stall, 1);
        chk({tag, "_acc_req"}, mreq, 0);
        chk({tag, "_acc_held_rd"}, {rd_valid, rd_data}, {1'b0, last_rd});
        @(posedge clk); #1;
        req = 0;
        for (int k = 0; k <= gdly; k++) begin
            gnt = (k == gdly);
            @(negedge clk);
            chk({tag, "_req"}, {mreq, stall}, 2'b11);
            chk({tag, "_addr"}, maddr, e.addr);
            if (chk_t) begin
                chk({tag, "_t_req"}, {t_mreq, t_stall}, (k < 4) ? 2'b11 : 2'b00);
                chk({tag, "_t_berr"}, t_berr, k == 5);
            end
            if (k == gdly) begin
                chk({tag, "_sbq"}, sb.size(), 1);
                g = sb.pop_front();
                chk({tag, "_be"}, mbe, g.be);
                chk({tag, "_we"}, mwe, g.we);
                chk({tag, "_wdata"}, mwdata, g.wdata);
                chk({tag, "_berr"}, berr, 0);
            end
            @(posedge clk); #1;
        end
        gnt = 0;
        for (int k = 0; k <= rdly; k++) begin
            rvalid = (k == rdly);
            rdata = rvalid ? bus : 32'hBAD0BAD0;
            @(negedge clk);
            chk({tag, "_mreq_off"}, mreq, 0);
            if (chk_t) chk({tag, "_t_rdv"}, t_rd_valid, 0);
            if (k < rdly) begin
                chk({tag, "_wait"}, {stall, rd_valid, rd_data}, {2'b10, last_rd});
            end else begin
                chk({tag, "_done_stall"}, stall, 0);
                chk({tag, "_rd_valid"}, rd_valid, !we);
                chk({tag, "_rd_data"}, rd_data, we ? last_rd : g.rd);
                chk({tag, "_pulses"}, {mis, berr}, 2'b00);
                if (!we) last_rd = g.rd;
            end
            @(posedge clk); #1;
        end
        rvalid = 0;
        rdata = 0;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_out, 0);
        chk("reset_outs_t", t_all_out, 0);
        @(posedge clk); #1;
        rst_n = 1;
        run_op("lw", 0, WORD, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, '{32'h100, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF});
        run_op("lb", 0, BYTE, 0, 32'h203, 0, 32'h80FF0000, 2, 1, 0, '{32'h200, 4'h8, 1'b0, 32'h0, 32'hFFFFFF80});
        run_op("lbu", 0, BYTE, 1, 32'h203, 0, 32'h80FF0000, 0, 3, 0, '{32'h200, 4'h8, 1'b0, 32'h0, 32'h00000080});
        run_op("sh", 1, HALF, 0, 32'h12, 32'h0000ABCD, 0, 1, 0, 0, '{32'h10, 4'hC, 1'b1, 32'hABCDABCD, 32'h0});
        run_op("lh", 0, HALF, 0, 32'h6, 0, 32'h80011234, 0, 0, 0, '{32'h4, 4'hC, 1'b0, 32'h0, 32'hFFFF8001});
        run_op("lhu", 0, HALF, 1, 32'h8, 0, 32'h5555F00D, 1, 0, 0, '{32'h8, 4'h3, 1'b0, 32'h0, 32'h0000F00D});
        run_op("sb", 1, BYTE, 0, 32'h1, 32'hFFFFFF5A, 0, 0, 2, 0, '{32'h0, 4'h2, 1'b1, 32'h5A5A5A5A, 32'h0});
        run_op("sw", 1, WORD, 0, 32'h20, 32'h11223344, 0, 0, 0, 0, '{32'h20, 4'hF, 1'b1, 32'h11223344, 32'h0});
        run_op("lw_slow", 0, WORD, 0, 32'h40, 0, 32'h12345678, 10, 0, 1, '{32'h40, 4'hF, 1'b0, 32'h0, 32'h12345678});
        req = 1; wr_en = 0; sz = WORD; zext = 0; addr = 32'h300;
        @(posedge clk); #1;
        req = 0; gnt = 1;
        @(posedge clk); #1;
        gnt = 0;
        rst_n = 0;
        #1;
        chk("rst_wait_outs", all_out, 0);
        @(posedge clk); #1;
        rst_n = 1; rvalid = 1; rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("rst_late_rvalid", {stall, rd_valid, rd_data, mreq, berr}, 0);
        @(posedge clk); #1;
        rvalid = 0; rdata = 0;
        last_rd = 0;
`ifdef SPARROW_LSU_MISALIGN_TRAP_EN
        req = 1; wr_en = 0; sz = WORD; addr = 32'h102;
        @(negedge clk);
        chk("mis_present", {stall, mreq, mis}, 3'b000);
        @(posedge clk); #1;
        req = 0;
        @(negedge clk);
        chk("mis_pulse", {mis, mreq, stall, rd_valid}, 4'b1000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_clear", {mis, mreq, stall}, 3'b000);
        @(posedge clk); #1;
`else
        run_op("lw_mis", 0, WORD, 0, 32'h102, 0, 32'hCAFEF00D, 0, 0, 0, '{32'h100, 4'hF, 1'b0, 32'h0, 32'hCAFEF00D});
        @(negedge clk);
        chk("mis_tied", mis, 0);
        @(posedge clk); #1;
`endif
        run_op("lw_after", 0, WORD, 0, 32'h80, 0, 32'h0BADF00D, 0, 0, 0, '{32'h80, 4'hF, 1'b0, 32'h0, 32'h0BADF00D});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
